// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares one data memory between the core load/store path and a
// debug/loader port.
//
// Ports
//   clk_i, rst_i                   clock, synchronous active-high reset
//   core_req_i/we_i/addr_i/wdata_i/funct3_i   core access request
//   core_gnt_o, core_stall_o       same-cycle grant, stall (req & ~gnt)
//   core_rvalid_o, core_rdata_o    registered read return, one-cycle pulse
//   dbg_*_i, dbg_lock_i            debug access request, burst lock request
//   dbg_gnt_o, dbg_rvalid_o, dbg_rdata_o      debug grant and read return
//   mem_addr_o/wdata_o/we_o/funct3_o          to data memory
//   mem_rdata_i                    combinational read data from memory
//
// Arbitration is round-robin on contention. A locking debug port may keep the
// grant for up to MAX_LOCK consecutive cycles before the core is let in.
module dmem_arbiter #(
    parameter int BITNESS  = 32,
    parameter int MAX_LOCK = 4
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               core_req_i,
    input  logic               core_we_i,
    input  logic [BITNESS-1:0] core_addr_i,
    input  logic [BITNESS-1:0] core_wdata_i,
    input  logic [2:0]         core_funct3_i,
    output logic               core_gnt_o,
    output logic               core_stall_o,
    output logic               core_rvalid_o,
    output logic [BITNESS-1:0] core_rdata_o,
    input  logic               dbg_req_i,
    input  logic               dbg_we_i,
    input  logic [BITNESS-1:0] dbg_addr_i,
    input  logic [BITNESS-1:0] dbg_wdata_i,
    input  logic [2:0]         dbg_funct3_i,
    input  logic               dbg_lock_i,
    output logic               dbg_gnt_o,
    output logic               dbg_rvalid_o,
    output logic [BITNESS-1:0] dbg_rdata_o,
    output logic [BITNESS-1:0] mem_addr_o,
    output logic [BITNESS-1:0] mem_wdata_o,
    output logic               mem_we_o,
    output logic [2:0]         mem_funct3_o,
    input  logic [BITNESS-1:0] mem_rdata_i
);

    localparam int CNT_W = $clog2(MAX_LOCK + 1);
    localparam logic [CNT_W-1:0] LOCK_MAX = CNT_W'(MAX_LOCK);

    logic               last;        // 0 = core won last grant, 1 = dbg
    logic [CNT_W-1:0]   lock_cnt;
    logic               rpend;       // a read was granted in the previous cycle
    logic               rsel;        // owner of that read: 0 = core, 1 = dbg
    logic [BITNESS-1:0] core_rdata_q;
    logic [BITNESS-1:0] dbg_rdata_q;

    logic core_gnt;
    logic dbg_gnt;
    logic lock_active;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == LOCK_MAX) ? v : v + 1'b1;
    endfunction

    // Lock only holds the grant for dbg while it already owns the memory.
    assign lock_active = last & dbg_lock_i & (lock_cnt < LOCK_MAX);

    always_comb begin
        core_gnt = 1'b0;
        dbg_gnt  = 1'b0;
        if (!rst_i) begin
            if (core_req_i && !dbg_req_i) begin
                core_gnt = 1'b1;
            end else if (dbg_req_i && !core_req_i) begin
                dbg_gnt = 1'b1;
            end else if (core_req_i && dbg_req_i) begin
                if (lock_active || !last) begin
                    dbg_gnt = 1'b1;
                end else begin
                    core_gnt = 1'b1;
                end
            end
        end
    end

    assign core_gnt_o   = core_gnt;
    assign dbg_gnt_o    = dbg_gnt;
    assign core_stall_o = core_req_i & ~core_gnt & ~rst_i;

    // Idle cycles park the address/data mux on the core inputs.
    assign mem_addr_o   = dbg_gnt ? dbg_addr_i   : core_addr_i;
    assign mem_wdata_o  = dbg_gnt ? dbg_wdata_i  : core_wdata_i;
    assign mem_funct3_o = dbg_gnt ? dbg_funct3_i : core_funct3_i;
    assign mem_we_o     = (core_gnt & core_we_i) | (dbg_gnt & dbg_we_i);

    // Stage boundary: grant cycle -> read-return cycle.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            last         <= 1'b1;
            lock_cnt     <= '0;
            rpend        <= 1'b0;
            rsel         <= 1'b0;
            core_rdata_q <= '0;
            dbg_rdata_q  <= '0;
        end else begin
            if (core_gnt) begin
                last     <= 1'b0;
                lock_cnt <= '0;
            end else if (dbg_gnt) begin
                last     <= 1'b1;
                lock_cnt <= dbg_lock_i ? sat_inc(lock_cnt) : '0;
            end
            rpend <= (core_gnt & ~core_we_i) | (dbg_gnt & ~dbg_we_i);
            rsel  <= dbg_gnt;
            if (core_gnt && !core_we_i) begin
                core_rdata_q <= mem_rdata_i;
            end
            if (dbg_gnt && !dbg_we_i) begin
                dbg_rdata_q <= mem_rdata_i;
            end
        end
    end

    // Reset suppresses a read return already in flight.
    assign core_rvalid_o = rpend & ~rsel & ~rst_i;
    assign dbg_rvalid_o  = rpend &  rsel & ~rst_i;
    assign core_rdata_o  = core_rdata_q;
    assign dbg_rdata_o   = dbg_rdata_q;

endmodule
